// File: rtl/usb_frame_packer.sv
// usb_frame_packer: packs a byte stream into big-endian words and frames them (header, length, payload, ~sum) onto the USB write port.
// Optional idle auto-flush is compiled in with the USB_PACKER_TIMEOUT_EN macro.
module usb_frame_packer #(
   parameter int unsigned PAYLOAD_WORDS  = 64,
   parameter int unsigned FIFO_DEPTH     = 128,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter logic [15:0] HEADER_WORD    = 16'hA55A
) (
   input  logic        CLOCK_50,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   output logic [15:0] usb_write_data,
   output logic        usb_write_en,
   input  logic        usb_write_wait,
   output logic [15:0] frame_count,
   output logic        busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {IDLE, PAD, HDR, LEN, PAY, SUM} state_t;

   state_t        state;
   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [7:0]    odd_byte;
   logic          have_odd, flush_pend;
   logic [15:0]   len, remain, sum;
   logic          take, accept, push, pop, flush_in, start_full, to_pad, to_hdr, discard;
   logic [15:0]   push_word;

   assign in_ready   = count != CW'(FIFO_DEPTH) && state != PAD;
   assign take       = in_valid && in_ready;
   assign accept     = usb_write_en && !usb_write_wait;
   assign push       = have_odd && (take || state == PAD);
   assign push_word  = {odd_byte, state == PAD ? 8'h00 : in_data};
   assign pop        = accept && (state == LEN || (state == PAY && remain != 16'd0));
   assign busy       = state != IDLE;
   assign start_full = count >= CW'(PAYLOAD_WORDS);
   assign to_pad     = state == IDLE && !start_full && flush_pend && have_odd;
   assign to_hdr     = state == PAD || (state == IDLE && (start_full || (flush_pend && !have_odd && count != '0)));
   assign discard    = state == IDLE && flush_pend && !have_odd && count == '0;

`ifdef USB_PACKER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt;
   logic          idle_run, tmo;
   assign idle_run = state == IDLE && (count != '0 || have_odd) && !take;
   assign tmo      = idle_run && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
   assign flush_in = flush || tmo;
   always_ff @(posedge CLOCK_50 or negedge rst_n)
      if (!rst_n) idle_cnt <= '0;
      else idle_cnt <= (idle_run && !tmo) ? idle_cnt + 1'b1 : '0;
`else
   assign flush_in = flush;
`endif

   always_ff @(posedge CLOCK_50)
      if (push) mem[wr_ptr] <= push_word;

   always_ff @(posedge CLOCK_50 or negedge rst_n)
      if (!rst_n) begin
         state          <= IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         odd_byte       <= '0;
         have_odd       <= 1'b0;
         flush_pend     <= 1'b0;
         len            <= '0;
         remain         <= '0;
         sum            <= '0;
         usb_write_en   <= 1'b0;
         usb_write_data <= '0;
         frame_count    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if (take) begin
            have_odd <= !have_odd;
            odd_byte <= in_data;
         end else if (state == PAD) have_odd <= 1'b0;
         // a flush landing on the HDR-entry edge survives and closes the following frame
         flush_pend <= (flush_pend && !to_hdr && !discard) || flush_in;
         case (state)
            IDLE: state <= to_hdr ? HDR : to_pad ? PAD : IDLE;
            PAD:  state <= HDR;
            HDR:
               if (!usb_write_en) begin
                  len            <= start_full ? 16'(PAYLOAD_WORDS) : 16'(count);
                  sum            <= '0;
                  usb_write_en   <= 1'b1;
                  usb_write_data <= HEADER_WORD;
               end else if (accept) begin
                  state          <= LEN;
                  usb_write_data <= len;
               end
            LEN:
               if (accept) begin
                  state          <= PAY;
                  usb_write_data <= mem[rd_ptr];
                  remain         <= len - 16'd1;
               end
            PAY:
               if (accept) begin
                  sum <= sum + usb_write_data;
                  if (remain == 16'd0) begin
                     state          <= SUM;
                     usb_write_data <= ~(sum + usb_write_data);
                  end else begin
                     usb_write_data <= mem[rd_ptr];
                     remain         <= remain - 16'd1;
                  end
               end
            SUM:
               if (accept) begin
                  state        <= IDLE;
                  usb_write_en <= 1'b0;
                  frame_count  <= frame_count + 16'd1;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_usb_frame_packer.sv
// tb_usb_frame_packer: randomized scoreboard bench; expected frames come from a byte-stream framing model.
module tb_usb_frame_packer;
   logic        CLOCK_50 = 0, rst_n = 0, in_valid = 0, flush = 0, usb_write_wait = 0;
   logic [7:0]  in_data = 0;
   logic        in_ready, usb_write_en, busy;
   logic [15:0] usb_write_data, frame_count;

   typedef struct {logic [15:0] w; bit last;} exp_t;
   exp_t        sb[$];
   exp_t        e;
   logic [7:0]  tx [4096];
   int          tp = 0, n_cmp = 0, n_err = 0, cyc = 0, exp_frames = 0, rise_cyc = -1, last_acc = 0;
   int          sent = 0, wait_mode = 0, widx = 0, hold = 0, after = 0;
   bit          pe = 0, pw = 0, pend_hold = 0, prev_en = 0;
   logic [15:0] hold_data = 0;

   usb_frame_packer #(.PAYLOAD_WORDS(64), .FIFO_DEPTH(128), .TIMEOUT_CYCLES(100), .HEADER_WORD(16'hA55A)) dut (
      .CLOCK_50(CLOCK_50), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .usb_write_data(usb_write_data), .usb_write_en(usb_write_en),
      .usb_write_wait(usb_write_wait), .frame_count(frame_count), .busy(busy));

   always #5 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: bound expired", name);
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   // frame of nb bytes starting at tx[s]: header, word count, packed words (odd tail padded), ~sum
   task automatic expect_frame(input int s, input int nb);
      logic [15:0] w;
      logic [15:0] sum = 0;
      int nw = (nb + 1) / 2;
      sb.push_back('{16'hA55A, 1'b0});
      sb.push_back('{16'(nw), 1'b0});
      for (int j = 0; j < nw; j++) begin
         w = {tx[s+2*j], (2*j+1 < nb) ? tx[s+2*j+1] : 8'h00};
         sum += w;
         sb.push_back('{w, 1'b0});
      end
      sb.push_back('{~sum, 1'b1});
      exp_frames++;
   endtask

   task automatic expect_bytes(input int s, input int n);
      for (int f = 0; f < n / 128; f++) expect_frame(s + 128*f, 128);
      if (n % 128 != 0) expect_frame(s + n - n % 128, n % 128);
   endtask

   task automatic fill(input int n, input bit rnd);
      for (int i = 0; i < n; i++) tx[tp+i] = rnd ? 8'($urandom) : 8'(i);
   endtask

   task automatic send(input int s, input int n, input bit fl);
      int g = 0;
      bit acc;
      sent = 0;
      while (sent < n && g < 20000) begin
         in_valid = 1;
         in_data  = tx[s+sent];
         acc      = in_ready;
         flush    = fl && acc && sent == n - 1;
         tick();
         g++;
         if (acc) begin
            sent++;
            last_acc = cyc;
         end
      end
      in_valid = 0;
      flush    = 0;
      if (sent < n) fail("send_timeout");
   endtask

   task automatic drain();
      int g = 0;
      while ((sb.size() != 0 || busy) && g < 20000) begin
         tick();
         g++;
      end
      if (g >= 20000) fail("drain_timeout");
      repeat (3) tick();
      chk("frame_count", frame_count, exp_frames);
   endtask

   // backpressure generator; mode 3 stalls 5 cycles on the LEN word and on the 9th payload word
   initial forever begin
      tick();
      if (pe && !pw) begin
         widx++;
         hold = 0;
      end
      if (!usb_write_en) widx = 0;
      case (wait_mode)
         0: usb_write_wait = 0;
         1: usb_write_wait = ($urandom % 3 == 0);
         2: usb_write_wait = 1;
         default: begin
            usb_write_wait = usb_write_en && (widx == 1 || widx == 10) && hold < 5;
            if (usb_write_wait) hold++;
         end
      endcase
      pe = usb_write_en;
      pw = usb_write_wait;
   end

   always @(negedge CLOCK_50) begin
      if (!rst_n) begin
         pend_hold = 0;
         prev_en   = 0;
         after     = 0;
      end else begin
         if (after == 1) chk("no_gap_in_frame", usb_write_en, 1);
         if (after == 2) chk("gap_after_sum", usb_write_en, 0);
         if (pend_hold) chk("hold_stable", {usb_write_en, usb_write_data}, {1'b1, hold_data});
         after = 0;
         if (usb_write_en && !prev_en) rise_cyc = cyc;
         pend_hold = usb_write_en && usb_write_wait;
         hold_data = usb_write_data;
         prev_en   = usb_write_en;
         if (usb_write_en && !usb_write_wait) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_write: got %0h, expected no write", usb_write_data);
            end else begin
               e = sb.pop_front();
               chk("word", usb_write_data, e.w);
               after = e.last ? 2 : 1;
            end
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, g;
      bit fl;
      tick();
      tick();
      chk("rst_en", usb_write_en, 0);
      chk("rst_data", usb_write_data, 0);
      chk("rst_frame_count", frame_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      rst_n = 1;
      tick();

      fill(128, 0);
      expect_bytes(tp, 128);
      rise_cyc = -1;
      send(tp, 128, 0);
      drain();
      chk("start_latency", rise_cyc - last_acc, 2);
      tp += 128;

      wait_mode = 3;
      fill(128, 1);
      expect_bytes(tp, 128);
      send(tp, 128, 0);
      drain();
      tp += 128;
      wait_mode = 0;

      tx[tp] = 8'h11; tx[tp+1] = 8'h22; tx[tp+2] = 8'h33;
      expect_bytes(tp, 3);
      send(tp, 3, 0);
      tick();
      flush = 1;
      tick();
      flush = 0;
      drain();
      tp += 3;

      for (int i = 0; i < 4; i++) tx[tp+i] = 8'(i + 1);
      expect_bytes(tp, 4);
      send(tp, 4, 1);
      drain();
      tp += 4;

      for (int k = 0; k < 8; k++) begin
         n = $urandom_range(1, 250);
         if (n == 128) n = 129;
         fl = 1'($urandom);
         wait_mode = $urandom_range(0, 2);
         if (wait_mode == 2) wait_mode = 3;
         fill(n, 1);
         expect_bytes(tp, n);
         send(tp, n, fl);
         if (!fl) begin
            flush = 1;
            tick();
            flush = 0;
         end
         drain();
         tp += n;
      end

      wait_mode = 2;
      fill(512, 1);
      expect_bytes(tp, 512);
      fork
         send(tp, 512, 0);
      join_none
      g = 0;
      while (in_ready && g < 3000) begin
         tick();
         g++;
      end
      if (g >= 3000) fail("fifo_full_wait");
      tick();
      chk("full_bytes_accepted", sent, 256);
      chk("full_in_ready_low", in_ready, 0);
      chk("full_busy", busy, 1);
      wait_mode = 1;
      g = 0;
      while (sent < 512 && g < 20000) begin
         tick();
         g++;
      end
      tick();
      drain();
      tp += 512;
      wait_mode = 0;

      fill(2, 1);
`ifdef USB_PACKER_TIMEOUT_EN
      expect_bytes(tp, 2);
      rise_cyc = -1;
      send(tp, 2, 0);
      drain();
      chk("timeout_latency", rise_cyc - last_acc, 102);
`else
      rise_cyc = -1;
      send(tp, 2, 0);
      repeat (1000) tick();
      chk("no_timeout_write", rise_cyc, -1);
      chk("no_timeout_frames", frame_count, exp_frames);
      expect_bytes(tp, 2);
      flush = 1;
      tick();
      flush = 0;
      drain();
`endif
      tp += 2;

      wait_mode = 2;
      fill(128, 1);
      expect_bytes(tp, 128);
      send(tp, 128, 0);
      repeat (4) tick();
      chk("stalled_en", usb_write_en, 1);
      rst_n = 0;
      #1;
      chk("async_en_drop", usb_write_en, 0);
      sb.delete();
      exp_frames = 0;
      wait_mode = 0;
      tick();
      rst_n = 1;
      tick();
      chk("post_rst_frame_count", frame_count, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_in_ready", in_ready, 1);
      repeat (200) tick();
      tp += 128;
      fill(4, 1);
      expect_bytes(tp, 4);
      send(tp, 4, 1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
